// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing an 8:1 one-bit mux between eight requesters.
// Registered one-hot grant plus select code, with a hold-time limit per grant.
module rr_mux_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t     state_r;
  logic [2:0] ptr_r;
  logic [7:0] cnt_r;
  logic [3:0] pick_s;
  logic       hit_s;
  logic [2:0] win_s;

  // Lowest offset from p wins; returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Wrapping priority search starting at the pointer.
  always_comb begin
    pick_s = rr_pick(req, ptr_r);
    hit_s  = pick_s[3];
    win_s  = pick_s[2:0];
  end

  // Arbitration state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      ptr_r   <= 3'd0;
      cnt_r   <= 8'd0;
      gnt     <= 8'h00;
      sel     <= 3'd0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          timeout <= 1'b0;
          if (en && hit_s) begin
            gnt     <= 8'd1 << win_s;
            sel     <= win_s;
            valid   <= 1'b1;
            cnt_r   <= 8'd0;
            ptr_r   <= win_s + 3'd1;
            state_r <= GRANT;
          end else begin
            // sel is held so the shared mux output stays stable while idle
            gnt     <= 8'h00;
            valid   <= 1'b0;
            state_r <= IDLE;
          end
        end
        GRANT: begin
          if (!req[sel]) begin
            gnt     <= 8'h00;
            valid   <= 1'b0;
            timeout <= 1'b0;
            state_r <= IDLE;
          end else if (cnt_r == HOLD_LAST) begin
            gnt     <= 8'h00;
            valid   <= 1'b0;
            timeout <= 1'b1;
            state_r <= IDLE;
          end else begin
            cnt_r   <= cnt_r + 8'd1;
            timeout <= 1'b0;
            state_r <= GRANT;
          end
        end
        default: begin
          state_r <= IDLE;
          gnt     <= 8'h00;
          valid   <= 1'b0;
          timeout <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter; two instances (HOLD_MAX 16 and 4) share stimulus.
module tb_rr_mux_arbiter;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt16, gnt4;
  logic [2:0] sel16, sel4;
  logic       valid16, valid4, timeout16, timeout4;
  int         n_checks;
  int         n_pass;

  rr_mux_arbiter #(.HOLD_MAX(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt16), .sel(sel16), .valid(valid16), .timeout(timeout16)
  );

  rr_mux_arbiter #(.HOLD_MAX(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt4), .sel(sel4), .valid(valid4), .timeout(timeout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected packed as {gnt, sel, valid, timeout}.
  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got gnt=%h sel=%0d valid=%b timeout=%b, expected gnt=%h sel=%0d valid=%b timeout=%b",
               tag, obs[12:5], obs[4:2], obs[1], obs[0], exp[12:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [12:0] pk(input logic [7:0] g, input logic [2:0] s,
                                     input logic v, input logic t);
    return {g, s, v, t};
  endfunction

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    en  = 1'b0;
    req = 8'h00;
    #1;
    check("reset_state16", {gnt16, sel16, valid16, timeout16}, pk(8'h00, 3'd0, 1'b0, 1'b0));
    check("reset_state4", {gnt4, sel4, valid4, timeout4}, pk(8'h00, 3'd0, 1'b0, 1'b0));

    // 1: no requests
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_noreq", {gnt16, sel16, valid16, timeout16}, pk(8'h00, 3'd0, 1'b0, 1'b0));
    end

    // 2: short request from requester 2
    do_reset();
    en  = 1'b1;
    req = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step();
      check("short_hold", {gnt16, sel16, valid16, timeout16}, pk(8'h04, 3'd2, 1'b1, 1'b0));
    end
    req = 8'h00;
    step();
    check("short_release", {gnt16, sel16, valid16, timeout16}, pk(8'h00, 3'd2, 1'b0, 1'b0));

    // 3: all requesting, HOLD_MAX = 4
    do_reset();
    en  = 1'b1;
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check("rr_grant", {gnt4, sel4, valid4, timeout4},
              pk(8'd1 << (k % 8), 3'(k % 8), 1'b1, 1'b0));
      end
      step();
      check("rr_timeout_gap", {gnt4, sel4, valid4, timeout4},
            pk(8'h00, 3'(k % 8), 1'b0, 1'b1));
    end

    // 4: pointer wrap after serving requester 5
    do_reset();
    en  = 1'b1;
    req = 8'h20;
    step();
    check("wrap_g5", {gnt16, sel16, valid16, timeout16}, pk(8'h20, 3'd5, 1'b1, 1'b0));
    req = 8'h00;
    step();
    check("wrap_rel5_sel_held", {gnt16, sel16, valid16, timeout16}, pk(8'h00, 3'd5, 1'b0, 1'b0));
    req = 8'h21;
    for (int i = 0; i < 16; i++) begin
      step();
      check("wrap_g0", {gnt16, sel16, valid16, timeout16}, pk(8'h01, 3'd0, 1'b1, 1'b0));
    end
    step();
    check("wrap_g0_timeout", {gnt16, sel16, valid16, timeout16}, pk(8'h00, 3'd0, 1'b0, 1'b1));
    step();
    check("wrap_then_g5", {gnt16, sel16, valid16, timeout16}, pk(8'h20, 3'd5, 1'b1, 1'b0));

    // 5: enable gating
    do_reset();
    en  = 1'b0;
    req = 8'h10;
    for (int i = 0; i < 5; i++) begin
      step();
      check("en_low_nogrant", {gnt16, sel16, valid16, timeout16}, pk(8'h00, 3'd0, 1'b0, 1'b0));
    end
    en = 1'b1;
    step();
    check("en_high_grant", {gnt16, sel16, valid16, timeout16}, pk(8'h10, 3'd4, 1'b1, 1'b0));
    step();
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_drop_persist", {gnt16, sel16, valid16, timeout16}, pk(8'h10, 3'd4, 1'b1, 1'b0));
    end
    req = 8'h00;
    step();
    check("en_req_drop", {gnt16, sel16, valid16, timeout16}, pk(8'h00, 3'd4, 1'b0, 1'b0));

    // 6: asynchronous reset mid-grant
    do_reset();
    en  = 1'b1;
    req = 8'h08;
    step();
    check("async_pre_g3", {gnt16, sel16, valid16, timeout16}, pk(8'h08, 3'd3, 1'b1, 1'b0));
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", {gnt16, sel16, valid16, timeout16}, pk(8'h00, 3'd0, 1'b0, 1'b0));
    step();
    rst = 1'b0;
    req = 8'h88;
    step();
    check("post_reset_ptr0", {gnt16, sel16, valid16, timeout16}, pk(8'h08, 3'd3, 1'b1, 1'b0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
